program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00: first instruction-memory word address written by a load.
REQ-002 SHALL have port clk  input  1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1: begin a load; sampled in IDLE or DONE only.
REQ-005 SHALL have port byte_valid  input  1: byte_data holds a valid byte.
REQ-006 SHALL have port byte_data  input  8: incoming program byte stream.
REQ-007 SHALL have port byte_ready  output  1: loader accepts a byte this cycle; transfer = byte_valid & byte_ready.
REQ-008 SHALL have port mem_we  output  1: instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port mem_addr  output  8: instruction-memory write address, same width as pc.
REQ-010 SHALL have port mem_wdata  output  16: instruction word to write.
REQ-011 SHALL have port cpu_hold  output  1: CPU must not fetch while high.
REQ-012 SHALL have port done  output  1: last load completed.
REQ-013 SHALL have port word_count  output  9: words written in current/last load.
REQ-014 SHALL have port error  output  1: checksum mismatch (see Configuration).

Function
REQ-015 SHALL implement states IDLE, LEN, HI, LO, WRITE, CHK, DONE.
REQ-016 SHALL assert byte_ready only in LEN, HI, LO, CHK; no byte consumed in any other state.
REQ-017 IDLE/DONE: start=1 -> LEN next cycle; load word_count=0, address pointer=BASE_ADDR, checksum accumulator=0, done=0, error=0.
REQ-018 Start SHALL be ignored in LEN, HI, LO, WRITE, CHK.
REQ-019 LEN: on transfer, latch N=byte_data (0 means 256 words) -> HI.
REQ-020 HI: on transfer, latch high byte -> LO; LO: on transfer, latch low byte -> WRITE.
REQ-021 WRITE: mem_we=1 for exactly one cycle, mem_addr=pointer, mem_wdata={high,low}; word_count increments.
REQ-022 After WRITE: pointer increments modulo 256 (255 wraps to 0); if word_count reaches N -> CHK when LOADER_CHECKSUM_EN defined, else DONE; otherwise -> HI.
REQ-023 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_wdata may hold last values otherwise.
REQ-024 cpu_hold SHALL be 1 in LEN, HI, LO, WRITE, CHK and 0 in IDLE and DONE.
REQ-025 DONE: done=1, remain until start or reset; word_count holds final value.
REQ-026 Stall: byte_valid=0 in any accepting state SHALL hold state and all latched data indefinitely.
REQ-027 Minimum load time for N words with byte_valid stuck high: 1 + 3N cycles (+1 for CHK) from LEN entry to DONE entry.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, word_count=0, error=0.
REQ-029 Reset mid-load SHALL abort without further writes; words already written stay in memory; no partial word written.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: after last word, CHK accepts one byte; accumulator = XOR of length byte and all data bytes; error=1 if received byte differs, else 0; then DONE.
REQ-031 Macro LOADER_CHECKSUM_EN undefined: CHK never entered, no trailing byte consumed, error tied 0.

Verification
REQ-032 Reset then start, stream 02,12,34,AB,CD (+chk 02^12^34^AB^CD=42) -> writes 1234@00, ABCD@01; done=1, word_count=2, error=0.
REQ-033 Same stream with chk byte 43 -> both words written, done=1, error=1 (checksum build only).
REQ-034 BASE_ADDR=8'hFF, N=2, words 0001,0002 -> writes 0001@FF, 0002@00 (wrap).
REQ-035 N byte=00, 256 words of value i -> 256 writes, addresses 00..FF, word_count=256.
REQ-036 byte_valid toggled 1/0 every cycle, N=1 -> identical write, completion delayed, start pulses mid-load ignored.
REQ-037 rst_n low after HI accepted -> immediate IDLE, mem_we never pulses, cpu_hold=0, done=0.

Source files
------------

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Receives a program as a byte stream and writes it into instruction memory
//   as 16-bit words. The CPU is held off instruction fetch for the whole load.
//   Stream format: one length byte N (0 stands for 256 words), then N words,
//   each sent as its high byte followed by its low byte. When the optional
//   checksum is built in, one more byte follows the last word.
//   The stream is accepted with a valid/ready handshake; a byte moves on any
//   rising edge where byte_valid and byte_ready are both high.
//
// Optional feature (compile-time macro):
//   LOADER_CHECKSUM_EN - after the last word, the loader accepts one checksum
//                        byte. error is set when that byte is not the XOR of
//                        the length byte and every data byte. When the macro
//                        is not defined, no trailing byte is consumed and
//                        error is tied low.
//
// Parameters:
//   BASE_ADDR   - instruction-memory address that receives the first word
//
// Ports:
//   clk         in   1  clock, rising edge
//   rst_n       in   1  asynchronous reset, active low
//   start       in   1  begin a load (sampled only when idle or done)
//   byte_valid  in   1  byte_data holds a valid byte
//   byte_data   in   8  program byte stream
//   byte_ready  out  1  loader accepts a byte this cycle
//   mem_we      out  1  instruction-memory write strobe, one cycle per word
//   mem_addr    out  8  instruction-memory write address
//   mem_wdata   out 16  instruction word to write
//   cpu_hold    out  1  CPU must not fetch while high
//   done        out  1  last load completed
//   word_count  out  9  words written in the current or last load
//   error       out  1  checksum mismatch on the last load
// ---------------------------------------------------------------------------
module program_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic [8:0]  word_count,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [8:0]  word_count_q, word_count_d;
    logic        byte_ready_q, byte_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  acc_q, acc_d;
    logic        error_q, error_d;
`endif

    logic        xfer;
    logic [8:0]  target_words;
    logic [8:0]  count_inc;

    assign xfer         = byte_valid & byte_ready_q;
    // A length byte of zero encodes the full 256-word image.
    assign target_words = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
    assign count_inc    = word_count_q + 9'd1;

    // Next-state logic. Every output is derived from the next state and
    // registered, so outputs change cleanly on the clock edge that enters a
    // state and never glitch with byte_valid.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        ptr_d        = ptr_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
`ifdef LOADER_CHECKSUM_EN
        acc_d        = acc_q;
        error_d      = error_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LEN;
                    word_count_d = 9'd0;
                    ptr_d        = BASE_ADDR;
                    done_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    acc_d        = 8'd0;
                    error_d      = 1'b0;
`endif
                end
            end

            S_LEN: begin
                if (xfer) begin
                    len_d   = byte_data;
                    state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
                    acc_d   = acc_q ^ byte_data;
`endif
                end
            end

            S_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
                    acc_d   = acc_q ^ byte_data;
`endif
                end
            end

            // The whole word is captured into the write registers here, so a
            // reset before WRITE can never leave a partial word behind.
            S_LO: begin
                if (xfer) begin
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = {hi_q, byte_data};
                    state_d     = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                    acc_d       = acc_q ^ byte_data;
`endif
                end
            end

            // The 8-bit pointer wraps naturally from 8'hFF to 8'h00.
            S_WRITE: begin
                word_count_d = count_inc;
                ptr_d        = ptr_q + 8'd1;
                if (count_inc == target_words) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_HI;
                end
            end

            S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) begin
                    error_d = (byte_data != acc_q);
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`else
                // Unreachable without the checksum; fall through to DONE.
                state_d = S_DONE;
                done_d  = 1'b1;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
                       (state_d == S_LO)  || (state_d == S_CHK);
        mem_we_d     = (state_d == S_WRITE);
        cpu_hold_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers; reset aborts any load immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= 8'd0;
            hi_q         <= 8'd0;
            ptr_q        <= 8'd0;
            word_count_q <= 9'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 8'd0;
            mem_wdata_q  <= 16'd0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            acc_q        <= 8'd0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            ptr_q        <= ptr_d;
            word_count_q <= word_count_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
`ifdef LOADER_CHECKSUM_EN
            acc_q        <= acc_d;
            error_q      <= error_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign word_count = word_count_q;
`ifdef LOADER_CHECKSUM_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Directed testbench for program_loader. Two instances share every input:
// the default one (BASE_ADDR 8'h00) and one with BASE_ADDR 8'hFF used for the
// address wrap case. Writes from each instance are logged on the falling edge.
// Honours LOADER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        byteValid;
    logic [7:0]  byteData;

    logic        byteReady, memWe, cpuHold, done, error;
    logic [7:0]  memAddr;
    logic [15:0] memWdata;
    logic [8:0]  wordCount;

    logic        byteReadyB, memWeB, cpuHoldB, doneB, errorB;
    logic [7:0]  memAddrB;
    logic [15:0] memWdataB;
    logic [8:0]  wordCountB;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  logAddr[$];
    logic [15:0] logData[$];
    logic [7:0]  logAddrB[$];
    logic [15:0] logDataB[$];

    program_loader #(.BASE_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rstN), .start(start),
        .byte_valid(byteValid), .byte_data(byteData),
        .byte_ready(byteReady), .mem_we(memWe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .cpu_hold(cpuHold), .done(done),
        .word_count(wordCount), .error(error)
    );

    program_loader #(.BASE_ADDR(8'hFF)) dutWrap (
        .clk(clk), .rst_n(rstN), .start(start),
        .byte_valid(byteValid), .byte_data(byteData),
        .byte_ready(byteReadyB), .mem_we(memWeB), .mem_addr(memAddrB),
        .mem_wdata(memWdataB), .cpu_hold(cpuHoldB), .done(doneB),
        .word_count(wordCountB), .error(errorB)
    );

    // 10 ns clock; cycle counter for latency measurements.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction-memory write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (memWe) begin
            logAddr.push_back(memAddr);
            logData.push_back(memWdata);
        end
        if (memWeB) begin
            logAddrB.push_back(memAddrB);
            logDataB.push_back(memWdataB);
        end
    end

    // Global safety net so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_logs();
        logAddr.delete();
        logData.delete();
        logAddrB.delete();
        logDataB.delete();
    endtask

    // Pulses start for one cycle; returns on a falling edge.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns on the falling edge after it was taken.
    // Must be entered on a falling edge so back-to-back bytes have no gap.
    task automatic send_byte(input logic [7:0] b);
        byteValid = 1'b1;
        byteData  = b;
        for (int k = 0; k < 50; k++) begin
            if (byteReady) begin
                @(posedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("[TB] FAIL send_byte_timeout byte=%02h actual byte_ready=0 required=1", b);
    endtask

    task automatic wait_done(output int doneCyc);
        byteValid = 1'b0;
        doneCyc   = -1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                doneCyc = cyc;
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("[TB] FAIL wait_done_timeout actual done=0 required=1");
    endtask

    task automatic test_reset();
        rstN      = 1'b0;
        start     = 1'b0;
        byteValid = 1'b0;
        byteData  = 8'h00;
        #1;
        checks++; if (byteReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_byte_ready actual=%b required=0", byteReady); end
        checks++; if (memWe !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_we actual=%b required=0", memWe); end
        checks++; if (memAddr !== 8'h00) begin failures++; $display("[TB] FAIL reset_mem_addr actual=%h required=00", memAddr); end
        checks++; if (memWdata !== 16'h0000) begin failures++; $display("[TB] FAIL reset_mem_wdata actual=%h required=0000", memWdata); end
        checks++; if (cpuHold !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_hold actual=%b required=0", cpuHold); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done actual=%b required=0", done); end
        checks++; if (wordCount !== 9'd0) begin failures++; $display("[TB] FAIL reset_word_count actual=%0d required=0", wordCount); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error actual=%b required=0", error); end
        checks++; if (memAddrB !== 8'h00) begin failures++; $display("[TB] FAIL reset_mem_addr_wrap actual=%h required=00", memAddrB); end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cpuHold !== 1'b0) begin failures++; $display("[TB] FAIL idle_cpu_hold actual=%b required=0", cpuHold); end
    endtask

    // 02,12,34,AB,CD -> 1234@00, ABCD@01, plus minimum-latency measurement.
    task automatic test_basic_load();
        int t0, t1, expCycles;
        clear_logs();
        do_start();
        t0 = cyc;
        checks++; if (cpuHold !== 1'b1) begin failures++; $display("[TB] FAIL basic_cpu_hold_loading actual=%b required=1", cpuHold); end
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h42);
        expCycles = 8;
`else
        expCycles = 7;
`endif
        wait_done(t1);
        checks++; if (t1 - t0 != expCycles) begin failures++; $display("[TB] FAIL basic_latency actual=%0d required=%0d", t1 - t0, expCycles); end
        checks++; if (logAddr.size() != 2) begin failures++; $display("[TB] FAIL basic_write_count actual=%0d required=2", logAddr.size()); end
        if (logAddr.size() == 2) begin
            checks++; if (logAddr[0] !== 8'h00 || logData[0] !== 16'h1234) begin failures++; $display("[TB] FAIL basic_write0 actual=%h@%h required=1234@00", logData[0], logAddr[0]); end
            checks++; if (logAddr[1] !== 8'h01 || logData[1] !== 16'hABCD) begin failures++; $display("[TB] FAIL basic_write1 actual=%h@%h required=ABCD@01", logData[1], logAddr[1]); end
        end
        checks++; if (wordCount !== 9'd2) begin failures++; $display("[TB] FAIL basic_word_count actual=%0d required=2", wordCount); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL basic_error actual=%b required=0", error); end
        checks++; if (cpuHold !== 1'b0) begin failures++; $display("[TB] FAIL basic_cpu_hold_done actual=%b required=0", cpuHold); end
        checks++; if (memWe !== 1'b0) begin failures++; $display("[TB] FAIL basic_mem_we_done actual=%b required=0", memWe); end
    endtask

    task automatic test_checksum();
        int t1;
`ifdef LOADER_CHECKSUM_EN
        clear_logs();
        do_start();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h43);
        wait_done(t1);
        checks++; if (logAddr.size() != 2) begin failures++; $display("[TB] FAIL chk_write_count actual=%0d required=2", logAddr.size()); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL chk_done actual=%b required=1", done); end
        checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL chk_error actual=%b required=1", error); end
`else
        // No checksum: a byte offered after completion must not be taken.
        t1 = 0;
        byteValid = 1'b1;
        byteData  = 8'h55;
        @(negedge clk);
        checks++; if (byteReady !== 1'b0) begin failures++; $display("[TB] FAIL no_trailing_byte_ready actual=%b required=0", byteReady); end
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL no_trailing_done actual=%b required=1", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL no_trailing_error actual=%b required=0", error); end
        byteValid = 1'b0;
`endif
    endtask

    // N=2, words 0001,0002 into the BASE_ADDR=FF instance -> FF then 00.
    task automatic test_wrap();
        int t1;
        clear_logs();
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h01);
`endif
        wait_done(t1);
        checks++; if (logAddrB.size() != 2) begin failures++; $display("[TB] FAIL wrap_write_count actual=%0d required=2", logAddrB.size()); end
        if (logAddrB.size() == 2) begin
            checks++; if (logAddrB[0] !== 8'hFF || logDataB[0] !== 16'h0001) begin failures++; $display("[TB] FAIL wrap_write0 actual=%h@%h required=0001@FF", logDataB[0], logAddrB[0]); end
            checks++; if (logAddrB[1] !== 8'h00 || logDataB[1] !== 16'h0002) begin failures++; $display("[TB] FAIL wrap_write1 actual=%h@%h required=0002@00", logDataB[1], logAddrB[1]); end
        end
        checks++; if (doneB !== 1'b1 || wordCountB !== 9'd2) begin failures++; $display("[TB] FAIL wrap_status actual done=%b count=%0d required done=1 count=2", doneB, wordCountB); end
    endtask

    // Length byte 00 -> 256 words of value i at address i.
    task automatic test_256_words();
        int t1;
        int badIdx;
        clear_logs();
        do_start();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00);
            send_byte(8'(i));
        end
`ifdef LOADER_CHECKSUM_EN
        // XOR of 0..255 is zero and the length byte is zero.
        send_byte(8'h00);
`endif
        wait_done(t1);
        checks++; if (logAddr.size() != 256) begin failures++; $display("[TB] FAIL full_write_count actual=%0d required=256", logAddr.size()); end
        badIdx = -1;
        for (int i = 0; i < logAddr.size() && i < 256; i++) begin
            if (badIdx < 0 && (logAddr[i] !== 8'(i) || logData[i] !== 16'(i))) badIdx = i;
        end
        checks++; if (badIdx >= 0) begin failures++; $display("[TB] FAIL full_write_content index=%0d actual=%h@%h required=%h@%h", badIdx, logData[badIdx], logAddr[badIdx], 16'(badIdx), 8'(badIdx)); end
        checks++; if (wordCount !== 9'd256) begin failures++; $display("[TB] FAIL full_word_count actual=%0d required=256", wordCount); end
        checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL full_error actual=%b required=0", error); end
    endtask

    // byte_valid toggles every cycle; start pulses in LO and WRITE are ignored.
    task automatic test_stall();
        logic [7:0] bytes [0:3];
        int n, idx, c, expC;
        bytes[0] = 8'h01;
        bytes[1] = 8'h5A;
        bytes[2] = 8'hA5;
        bytes[3] = 8'hFE;
`ifdef LOADER_CHECKSUM_EN
        n = 4; expC = 7;
`else
        n = 3; expC = 6;
`endif
        clear_logs();
        do_start();
        idx = 0;
        c   = 0;
        while (!done && c < 200) begin
            byteValid = (c % 2 == 0);
            byteData  = (idx < n) ? bytes[idx] : 8'h00;
            start     = (c == 3) || (c == 5);
            if (byteValid && byteReady) idx++;
            @(negedge clk);
            c++;
        end
        start     = 1'b0;
        byteValid = 1'b0;
        checks++; if (c != expC) begin failures++; $display("[TB] FAIL stall_cycles actual=%0d required=%0d", c, expC); end
        checks++; if (logAddr.size() != 1) begin failures++; $display("[TB] FAIL stall_write_count actual=%0d required=1", logAddr.size()); end
        if (logAddr.size() == 1) begin
            checks++; if (logAddr[0] !== 8'h00 || logData[0] !== 16'h5AA5) begin failures++; $display("[TB] FAIL stall_write actual=%h@%h required=5AA5@00", logData[0], logAddr[0]); end
        end
        checks++; if (wordCount !== 9'd1 || error !== 1'b0) begin failures++; $display("[TB] FAIL stall_status actual count=%0d error=%b required count=1 error=0", wordCount, error); end
    endtask

    // Reset asserted while waiting for the low byte: no write, immediate IDLE.
    task automatic test_reset_mid_load();
        clear_logs();
        do_start();
        send_byte(8'h01);
        send_byte(8'hAA);
        byteData = 8'hBB;
        rstN     = 1'b0;
        #1;
        checks++; if (cpuHold !== 1'b0) begin failures++; $display("[TB] FAIL midreset_cpu_hold actual=%b required=0", cpuHold); end
        checks++; if (byteReady !== 1'b0) begin failures++; $display("[TB] FAIL midreset_byte_ready actual=%b required=0", byteReady); end
        checks++; if (done !== 1'b0 || memWe !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done_we actual done=%b we=%b required done=0 we=0", done, memWe); end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        byteValid = 1'b0;
        checks++; if (logAddr.size() != 0) begin failures++; $display("[TB] FAIL midreset_writes actual=%0d required=0", logAddr.size()); end
        checks++; if (cpuHold !== 1'b0 || done !== 1'b0 || byteReady !== 1'b0) begin failures++; $display("[TB] FAIL midreset_idle actual hold=%b done=%b ready=%b required 0,0,0", cpuHold, done, byteReady); end
    endtask

    // Two loads in a row; the second restarts from DONE at BASE_ADDR.
    task automatic test_back_to_back();
        int t1;
        clear_logs();
        do_start();
        send_byte(8'h01);
        send_byte(8'hBE);
        send_byte(8'hEF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h50);
`endif
        wait_done(t1);
        do_start();
        checks++; if (done !== 1'b0 || wordCount !== 9'd0) begin failures++; $display("[TB] FAIL b2b_restart actual done=%b count=%0d required done=0 count=0", done, wordCount); end
        send_byte(8'h01);
        send_byte(8'h13);
        send_byte(8'h57);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h45);
`endif
        wait_done(t1);
        checks++; if (logAddr.size() != 2) begin failures++; $display("[TB] FAIL b2b_write_count actual=%0d required=2", logAddr.size()); end
        if (logAddr.size() == 2) begin
            checks++; if (logAddr[0] !== 8'h00 || logData[0] !== 16'hBEEF) begin failures++; $display("[TB] FAIL b2b_write0 actual=%h@%h required=BEEF@00", logData[0], logAddr[0]); end
            checks++; if (logAddr[1] !== 8'h00 || logData[1] !== 16'h1357) begin failures++; $display("[TB] FAIL b2b_write1 actual=%h@%h required=1357@00", logData[1], logAddr[1]); end
        end
        checks++; if (wordCount !== 9'd1 || error !== 1'b0) begin failures++; $display("[TB] FAIL b2b_status actual count=%0d error=%b required count=1 error=0", wordCount, error); end
    endtask

    initial begin
        $display("[TB] program_loader bench start");
        test_reset();
        test_basic_load();
        test_checksum();
        test_wrap();
        test_256_words();
        test_stall();
        test_reset_mid_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
